// File: rtl/bridge_slave_port_arb.sv
// bridge_slave_port_arb
// Round-robin arbiter that funnels N_MASTER request ports onto one slave
// port. Each granted request pushes the winning master index into a small
// routing FIFO; slave responses pop that FIFO in order and are steered back
// to the master that issued the request.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   data_req_i / gnt_o   : per-master request / grant
//   data_{add,wen,wdata,be,aux,ID}_i : per-master payload (wen 1 = read)
//   data_req_o / gnt_i   : slave request / grant
//   data_{add,wen,wdata,be,aux,ID}_o : winning master's payload, zero when idle
//   data_r_{valid,rdata,opc,aux}_i   : slave response
//   data_r_valid_o       : one-hot response strobe towards the masters
//   data_r_{rdata,opc,aux}_o         : response payload broadcast
//   outstanding_o        : routing FIFO occupancy
//   err_o                : sticky flag, response seen with nothing outstanding
//   rr_ptr_o             : debug view of the round-robin pointer
//
// Handshake: a request transfers on a cycle where data_req_o and data_gnt_i
// are both high; data_req_o never depends on data_gnt_i. A response is
// accepted on every cycle data_r_valid_i is high (no back-pressure).
module bridge_slave_port_arb #(
  parameter int N_MASTER        = 4,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int AUX_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTER-1:0]                 data_req_i,
  input  logic [ADDR_WIDTH-1:0]               data_add_i   [N_MASTER],
  input  logic                                data_wen_i   [N_MASTER],
  input  logic [DATA_WIDTH-1:0]               data_wdata_i [N_MASTER],
  input  logic [BE_WIDTH-1:0]                 data_be_i    [N_MASTER],
  input  logic [AUX_WIDTH-1:0]                data_aux_i   [N_MASTER],
  input  logic [ID_WIDTH-1:0]                 data_ID_i    [N_MASTER],
  output logic [N_MASTER-1:0]                 data_gnt_o,
  output logic                                data_req_o,
  input  logic                                data_gnt_i,
  output logic [ADDR_WIDTH-1:0]               data_add_o,
  output logic                                data_wen_o,
  output logic [DATA_WIDTH-1:0]               data_wdata_o,
  output logic [BE_WIDTH-1:0]                 data_be_o,
  output logic [AUX_WIDTH-1:0]                data_aux_o,
  output logic [ID_WIDTH-1:0]                 data_ID_o,
  input  logic                                data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]               data_r_rdata_i,
  input  logic                                data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]                data_r_aux_i,
  output logic [N_MASTER-1:0]                 data_r_valid_o,
  output logic [DATA_WIDTH-1:0]               data_r_rdata_o,
  output logic                                data_r_opc_o,
  output logic [AUX_WIDTH-1:0]                data_r_aux_o,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
  output logic                                err_o,
  output logic [$clog2(N_MASTER)-1:0]         rr_ptr_o
);

  localparam int IDX_W = $clog2(N_MASTER);
  localparam int FP_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = FP_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   cand;
  logic             any_req;

  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [FP_W-1:0]  wr_ptr;
  logic [FP_W-1:0]  rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             err_q;

  assign any_req    = |data_req_i;
  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  // Full gates new requests even if a pop happens this cycle, so the slot
  // freed by a pop becomes usable on the following cycle.
  assign data_req_o = any_req & ~fifo_full;
  assign push       = data_req_o & data_gnt_i;
  assign pop        = data_r_valid_i & ~fifo_empty;

  // Scan from rr_ptr upwards, wrapping modulo N_MASTER; first hit wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_MASTER)) cand = cand - (IDX_W+1)'(N_MASTER);
      // Descending scan so the lowest offset is the last (winning) assignment.
      if (data_req_i[cand[IDX_W-1:0]]) winner = cand[IDX_W-1:0];
    end
  end

  always_comb begin
    data_gnt_o = '0;
    if (push) data_gnt_o[winner] = 1'b1;
  end

  assign data_add_o   = any_req ? data_add_i[winner]   : '0;
  assign data_wen_o   = any_req ? data_wen_i[winner]   : 1'b0;
  assign data_wdata_o = any_req ? data_wdata_i[winner] : '0;
  assign data_be_o    = any_req ? data_be_i[winner]    : '0;
  assign data_aux_o   = any_req ? data_aux_i[winner]   : '0;
  assign data_ID_o    = any_req ? data_ID_i[winner]    : '0;

  // Response routing: the FIFO head names the master that owns this beat.
  always_comb begin
    data_r_valid_o = '0;
    if (pop && !rst) data_r_valid_o[fifo_q[rd_ptr]] = 1'b1;
  end

  assign data_r_rdata_o = data_r_valid_i ? data_r_rdata_i : '0;
  assign data_r_opc_o   = data_r_valid_i ? data_r_opc_i   : 1'b0;
  assign data_r_aux_o   = data_r_valid_i ? data_r_aux_i   : '0;

  assign outstanding_o = count;
  assign err_o         = err_q;
  assign rr_ptr_o      = rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (winner == IDX_W'(N_MASTER - 1)) ? '0 : winner + IDX_W'(1);
        wr_ptr <= wr_ptr + FP_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FP_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A response with nothing outstanding cannot be routed.
      if (data_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_bridge_slave_port_arb.sv
module tb_bridge_slave_port_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  data_req_i;
  logic [31:0] data_add_i   [4];
  logic        data_wen_i   [4];
  logic [31:0] data_wdata_i [4];
  logic [3:0]  data_be_i    [4];
  logic [7:0]  data_aux_i   [4];
  logic [3:0]  data_ID_i    [4];
  logic [3:0]  data_gnt_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_add_o;
  logic        data_wen_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic [7:0]  data_aux_o;
  logic [3:0]  data_ID_o;
  logic        data_r_valid_i;
  logic [31:0] data_r_rdata_i;
  logic        data_r_opc_i;
  logic [7:0]  data_r_aux_i;
  logic [3:0]  data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic [7:0]  data_r_aux_o;
  logic [2:0]  outstanding_o;
  logic        err_o;
  logic [1:0]  rr_ptr_o;

  int checks;
  int failures;
  logic [3:0] exp_q[$];
  logic [3:0] exp_oh;

  bridge_slave_port_arb #(
    .N_MASTER(4), .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .BE_WIDTH(4), .AUX_WIDTH(8), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_aux_i(data_aux_i),
    .data_ID_i(data_ID_i), .data_gnt_o(data_gnt_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_add_o(data_add_o), .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o),
    .data_be_o(data_be_o), .data_aux_o(data_aux_o), .data_ID_o(data_ID_o),
    .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i),
    .data_r_opc_i(data_r_opc_i), .data_r_aux_i(data_r_aux_i),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .data_r_opc_o(data_r_opc_o), .data_r_aux_o(data_r_aux_o),
    .outstanding_o(outstanding_o), .err_o(err_o), .rr_ptr_o(rr_ptr_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic gnt, input logic rv);
    data_req_i     = req;
    data_gnt_i     = gnt;
    data_r_valid_i = rv;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    data_req_i = '0;
    data_gnt_i = 1'b0;
    data_r_valid_i = 1'b0;
    data_r_rdata_i = '0;
    data_r_opc_i = 1'b0;
    data_r_aux_i = '0;
    for (int m = 0; m < 4; m++) begin
      data_add_i[m]   = 32'h100 * (m + 1);
      data_wen_i[m]   = m[0];
      data_wdata_i[m] = 32'hD0 + m;
      data_be_i[m]    = 4'hF ^ 4'(m);
      data_aux_i[m]   = 8'h10 + 8'(m);
      data_ID_i[m]    = 4'(m);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_rvalid", data_r_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rr", rr_ptr_o, 0);
    chk("rst_req_o", data_req_o, 0);
    rst = 1'b0;
    tick();

    // all four requesting: grants 0,1,2,3,0; each response pops the previous grant
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 1'b1, k > 0);
      chk("rr_gnt", data_gnt_o, 4'b1 << (k % 4));
      chk("rr_add", data_add_o, 32'h100 * ((k % 4) + 1));
      chk("rr_id", data_ID_o, k % 4);
      if (k > 0) chk("rr_rvalid", data_r_valid_o, 4'b1 << ((k - 1) % 4));
      tick();
    end
    drive(4'h0, 1'b0, 1'b1);
    chk("rr_drain_rvalid", data_r_valid_o, 4'b0001);
    chk("idle_add_zero", data_add_o, 0);
    tick();
    drive(4'h0, 1'b0, 1'b0);
    chk("rr_drain_cnt", outstanding_o, 0);
    chk("rr_ptr_after5", rr_ptr_o, 1);

    // masters 1 and 3 with rr_ptr=2
    drive(4'b0010, 1'b1, 1'b0);
    chk("m1_setup_gnt", data_gnt_o, 4'b0010);
    tick();
    chk("rr_is_2", rr_ptr_o, 2);
    drive(4'b1010, 1'b1, 1'b1);
    chk("m13_gnt3", data_gnt_o, 4'b1000);
    chk("m13_wen", data_wen_o, 1);
    chk("m13_rvalid1", data_r_valid_o, 4'b0010);
    tick();
    chk("rr_wrap0", rr_ptr_o, 0);
    drive(4'b1010, 1'b1, 1'b1);
    chk("m13_gnt1", data_gnt_o, 4'b0010);
    chk("m13_rvalid3", data_r_valid_o, 4'b1000);
    tick();
    drive(4'h0, 1'b0, 1'b1);
    chk("m13_rvalid1b", data_r_valid_o, 4'b0010);
    tick();

    // fill to full, then pop and observe one-cycle-late request
    for (int k = 0; k < 4; k++) begin
      drive(4'hF, 1'b1, 1'b0);
      chk("fill_gnt", data_gnt_o, 4'b1 << ((k + 2) % 4));
      tick();
    end
    drive(4'hF, 1'b1, 1'b0);
    chk("full_cnt", outstanding_o, 4);
    chk("full_req_o", data_req_o, 0);
    chk("full_gnt", data_gnt_o, 0);
    drive(4'hF, 1'b1, 1'b1);
    chk("full_pop_req_o", data_req_o, 0);
    chk("full_pop_rvalid", data_r_valid_o, 4'b0100);
    tick();
    drive(4'hF, 1'b0, 1'b0);
    chk("after_pop_req_o", data_req_o, 1);
    chk("after_pop_cnt", outstanding_o, 3);
    chk("stall_gnt", data_gnt_o, 0);
    tick();
    chk("stall_rr_hold", rr_ptr_o, 2);
    chk("stall_cnt_hold", outstanding_o, 3);
    for (int k = 0; k < 3; k++) begin
      drive(4'h0, 1'b0, 1'b1);
      chk("drain_rvalid", data_r_valid_o, 4'b1 << ((k + 3) % 4));
      tick();
    end

    // grants 2,0,1 then in-order responses 0xA,0xB,0xC
    for (int k = 0; k < 3; k++) begin
      exp_oh = (k == 0) ? 4'b0100 : (k == 1) ? 4'b0001 : 4'b0010;
      drive(exp_oh, 1'b1, 1'b0);
      chk("ord_gnt", data_gnt_o, exp_oh);
      exp_q.push_back(exp_oh);
      tick();
    end
    data_r_rdata_i = 32'hA;
    drive(4'h0, 1'b0, 1'b0);
    chk("rdata_zero_idle", data_r_rdata_o, 0);
    chk("ord_cnt", outstanding_o, 3);
    for (int k = 0; k < 3; k++) begin
      data_r_rdata_i = 32'hA + k;
      data_r_opc_i   = k[0];
      data_r_aux_i   = 8'h50 + 8'(k);
      drive(4'h0, 1'b0, 1'b1);
      exp_oh = exp_q.pop_front();
      chk("ord_rvalid", data_r_valid_o, exp_oh);
      chk("ord_rdata", data_r_rdata_o, 32'hA + k);
      chk("ord_opc", data_r_opc_o, k % 2);
      chk("ord_aux", data_r_aux_o, 8'h50 + k);
      tick();
    end

    // response with empty FIFO
    drive(4'h0, 1'b0, 1'b1);
    chk("empty_rvalid", data_r_valid_o, 0);
    chk("empty_err_pre", err_o, 0);
    tick();
    drive(4'h0, 1'b0, 1'b0);
    chk("empty_err_set", err_o, 1);
    chk("empty_cnt", outstanding_o, 0);
    repeat (3) tick();
    chk("err_sticky", err_o, 1);

    // reset with two outstanding
    drive(4'b0010, 1'b1, 1'b0);
    tick();
    drive(4'b0100, 1'b1, 1'b0);
    tick();
    drive(4'h0, 1'b0, 1'b1);
    chk("pre_rst_cnt", outstanding_o, 2);
    chk("pre_rst_rr", rr_ptr_o, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", outstanding_o, 0);
    chk("mid_rst_rr", rr_ptr_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_rvalid", data_r_valid_o, 0);
    data_r_valid_i = 1'b0;
    rst = 1'b0;
    drive(4'b1010, 1'b1, 1'b0);
    chk("post_rst_gnt", data_gnt_o, 4'b0010);
    tick();
    drive(4'h0, 1'b0, 1'b1);
    chk("post_rst_rvalid", data_r_valid_o, 4'b0010);
    tick();
    drive(4'h0, 1'b0, 1'b1);
    chk("stale_rvalid", data_r_valid_o, 0);
    tick();
    drive(4'h0, 1'b0, 1'b0);
    chk("stale_err", err_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bridge_slave_port_arb.md
BRIDGE_SLAVE_PORT_ARB -- requirements
Module: bridge_slave_port_arb

Interface
REQ-001 SHALL have parameter N_MASTER, default 4, number of requesting masters (>=2).
REQ-002 SHALL have parameter ID_WIDTH, default N_MASTER, width of the master ID carried with each request.
REQ-003 SHALL have parameters ADDR_WIDTH 32, DATA_WIDTH 32, BE_WIDTH DATA_WIDTH/8 and AUX_WIDTH 8, setting the payload field widths.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, the routing-FIFO depth (power of 2, >=2).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk input 1, clock; rst input 1, reset.
REQ-006 SHALL have data_req_i, input, N_MASTER bits, per-master request.
REQ-007 SHALL have data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i and data_ID_i as inputs, each [N_MASTER] x its field width (wen is 1 bit, 1=read), carrying per-master payload.
REQ-008 SHALL have data_gnt_o, output, N_MASTER bits, per-master grant.
REQ-009 SHALL have data_req_o output 1, data_gnt_i input 1, and outputs data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o and data_ID_o, forming the slave request port.
REQ-010 SHALL have inputs data_r_valid_i (1), data_r_rdata_i (DATA_WIDTH), data_r_opc_i (1) and data_r_aux_i (AUX_WIDTH), forming the slave response.
REQ-011 SHALL have outputs data_r_valid_o (N_MASTER, one-hot), data_r_rdata_o, data_r_opc_o and data_r_aux_o, forming the response broadcast to masters.
REQ-012 SHALL have outputs outstanding_o ($clog2(MAX_OUTSTANDING)+1 bits), the FIFO occupancy, and err_o (1), a sticky error flag.

Function
REQ-013 SHALL arbitrate round-robin among asserted data_req_i: winner = first asserted index at or above rr_ptr, wrapping modulo N_MASTER.
REQ-014 SHALL drive data_req_o = (|data_req_i) & !fifo_full, combinationally.
REQ-015 SHALL mux the winner's add/wen/wdata/be/aux/ID onto the slave port, and drive zero when no master requests.
REQ-016 SHALL assert data_gnt_o[winner] = data_gnt_i & data_req_o, with all other grant bits 0.
REQ-017 SHALL treat a handshake (data_req_o & data_gnt_i) as follows: push the winner index into the FIFO and set rr_ptr = (winner+1) mod N_MASTER on the next edge.
REQ-018 SHALL hold rr_ptr unchanged when there is no handshake, including a request stalled by a low data_gnt_i.
REQ-019 SHALL gate requests on full regardless of a same-cycle pop; a new grant is possible one cycle after a pop from the full state.
REQ-020 SHALL, when data_r_valid_i is asserted and the FIFO is not empty, set data_r_valid_o = onehot(FIFO head) in the same cycle and pop the head on the edge.
REQ-021 SHALL pass data_r_rdata/opc/aux through combinationally and zero them when data_r_valid_i=0.
REQ-022 SHALL, when data_r_valid_i is asserted with the FIFO empty, keep data_r_valid_o at 0, perform no pop, and set err_o=1 until reset.
REQ-023 SHALL leave occupancy unchanged on a same-cycle push and pop; a response in a given cycle always belongs to an older entry, since slave latency is >=1 cycle.
REQ-024 SHALL implement the FIFO pointers as wrap-around modulo MAX_OUTSTANDING, with outstanding_o = count, 0..MAX_OUTSTANDING.
REQ-025 SHALL keep responses in request order (in-order slave assumed by design).

Reset
REQ-026 SHALL, while rst=1, asynchronously force rr_ptr=0, FIFO pointers and count to 0, and err_o=0.
REQ-027 SHALL drive data_r_valid_o=0 and outstanding_o=0 while rst=1.
REQ-028 SHALL discard outstanding FIFO entries on reset mid-operation; later responses set err_o.
REQ-029 SHALL behave correctly at the first clk edge after rst deasserts.

Verification
REQ-030 SHALL cover: N_MASTER=4, all four requesting, data_gnt_i=1 for 4 cycles -> grants 0,1,2,3 in order, then 0 again.
REQ-031 SHALL cover: masters 1 and 3 requesting, rr_ptr=2 -> master 3 granted, then rr_ptr=0, then master 1 granted.
REQ-032 SHALL cover: 4 handshakes with no response -> outstanding_o=4, data_req_o=0 despite requests; one pop -> data_req_o=1 the following cycle.
REQ-033 SHALL cover: grants to masters 2,0,1, then three responses with rdata 0xA,0xB,0xC -> data_r_valid_o = 4'b0100, 4'b0001, 4'b0010 carrying 0xA, 0xB, 0xC.
REQ-034 SHALL cover: data_r_valid_i=1 with the FIFO empty -> data_r_valid_o=0 and err_o=1 held until rst.
REQ-035 SHALL cover: rst pulsed with 2 outstanding -> outstanding_o=0, rr_ptr=0, and the next grant goes to the lowest requesting index.
